// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin sharing of one GCD engine between NREQ requesters
module gcd_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int LATW  = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req_say__ENA,
  input  logic [NREQ*WIDTH-1:0] req_say_va,
  input  logic [NREQ*WIDTH-1:0] req_say_vb,
  output logic [NREQ-1:0]       req_say__RDY,
  output logic                  eng_say__ENA,
  output logic [WIDTH-1:0]      eng_say_va,
  output logic [WIDTH-1:0]      eng_say_vb,
  input  logic                  eng_say__RDY,
  input  logic                  eng_gcd__ENA,
  input  logic [WIDTH-1:0]      eng_gcd_v,
  output logic                  eng_gcd__RDY,
  output logic [NREQ-1:0]       ind_gcd__ENA,
  output logic [WIDTH-1:0]      ind_gcd_v,
  input  logic [NREQ-1:0]       ind_gcd__RDY,
  output logic                  busy,
  output logic [LATW-1:0]       last_latency
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  pend_q, pend_d;
  logic [WIDTH-1:0] va_q [NREQ];
  logic [WIDTH-1:0] vb_q [NREQ];
  logic [PW-1:0]    owner_q, owner_d, rr_ptr_q, rr_ptr_d, grant;
  logic [LATW-1:0]  lat_cnt_q, lat_cnt_d, last_latency_q, last_latency_d;
  logic             issue, xfer;

  // Modulo-NREQ add that also works when NREQ is not a power of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [PW:0] off);
    logic [PW:0] s;
    s = {1'b0, base} + off;
    if (s >= (PW+1)'(NREQ)) s = s - (PW+1)'(NREQ);
    return s[PW-1:0];
  endfunction

  // Descending scan so the offset closest to rr_ptr wins.
  always_comb begin
    grant = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (pend_q[wrap_add(rr_ptr_q, (PW+1)'(k))]) grant = wrap_add(rr_ptr_q, (PW+1)'(k));
    end
  end

  assign issue = (state_q == IDLE) && (|pend_q) && eng_say__RDY;
  assign xfer  = (state_q == BUSY) && eng_gcd__ENA && ind_gcd__RDY[owner_q];

  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = BUSY;
      BUSY:    if (xfer)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    eng_say__ENA = 1'b0;
    eng_gcd__RDY = 1'b0;
    ind_gcd__ENA = '0;
    busy         = 1'b0;
    eng_say_va   = va_q[grant];
    eng_say_vb   = vb_q[grant];
    case (state_q)
      IDLE: eng_say__ENA = (|pend_q) & eng_say__RDY;
      BUSY: begin
        busy                  = 1'b1;
        eng_gcd__RDY          = ind_gcd__RDY[owner_q];
        ind_gcd__ENA[owner_q] = eng_gcd__ENA;
      end
      default: ;
    endcase
  end

  assign ind_gcd_v    = eng_gcd_v;
  assign req_say__RDY = ~pend_q;
  assign last_latency = last_latency_q;

  always_comb begin
    pend_d         = pend_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    lat_cnt_d      = lat_cnt_q;
    last_latency_d = last_latency_q;
    if (state_q == BUSY && lat_cnt_q != '1) lat_cnt_d = lat_cnt_q + 1'b1;
    if (issue) begin
      pend_d[grant] = 1'b0;
      owner_d       = grant;
      lat_cnt_d     = LATW'(1);
    end
    if (xfer) begin
      last_latency_d = lat_cnt_q;
      rr_ptr_d       = wrap_add(owner_q, (PW+1)'(1));
    end
    // A slot being loaded is empty, so it can never be the one issuing this cycle.
    pend_d = pend_d | (req_say__ENA & ~pend_q);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pend_q         <= '0;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      lat_cnt_q      <= '0;
      last_latency_q <= '0;
    end else begin
      pend_q         <= pend_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      lat_cnt_q      <= lat_cnt_d;
      last_latency_q <= last_latency_d;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!nRST) begin
        va_q[i] <= '0;
        vb_q[i] <= '0;
      end else if (req_say__ENA[i] && !pend_q[i]) begin
        va_q[i] <= req_say_va[i*WIDTH +: WIDTH];
        vb_q[i] <= req_say_vb[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb/tb_gcd_arbiter.sv - scoreboard bench for gcd_arbiter with a behavioural engine
module tb_gcd_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 32;
  localparam int LATW = 16;
  localparam int ENG_DELAY = 2;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic [NREQ-1:0]       req_say__ENA;
  logic [NREQ*WIDTH-1:0] req_say_va, req_say_vb;
  logic [NREQ-1:0]       req_say__RDY;
  logic                  eng_say__ENA;
  logic [WIDTH-1:0]      eng_say_va, eng_say_vb;
  logic                  eng_say__RDY;
  logic                  eng_gcd__ENA;
  logic [WIDTH-1:0]      eng_gcd_v;
  logic                  eng_gcd__RDY;
  logic [NREQ-1:0]       ind_gcd__ENA;
  logic [WIDTH-1:0]      ind_gcd_v;
  logic [NREQ-1:0]       ind_gcd__RDY;
  logic                  busy;
  logic [LATW-1:0]       last_latency;

  gcd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LATW(LATW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_say__ENA(req_say__ENA), .req_say_va(req_say_va), .req_say_vb(req_say_vb),
    .req_say__RDY(req_say__RDY),
    .eng_say__ENA(eng_say__ENA), .eng_say_va(eng_say_va), .eng_say_vb(eng_say_vb),
    .eng_say__RDY(eng_say__RDY),
    .eng_gcd__ENA(eng_gcd__ENA), .eng_gcd_v(eng_gcd_v), .eng_gcd__RDY(eng_gcd__RDY),
    .ind_gcd__ENA(ind_gcd__ENA), .ind_gcd_v(ind_gcd_v), .ind_gcd__RDY(ind_gcd__RDY),
    .busy(busy), .last_latency(last_latency)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Behavioural engine: accepts one op, answers ENG_DELAY cycles later, holds until taken.
  function automatic logic [WIDTH-1:0] gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  logic             eng_busy;
  int               eng_cnt;
  logic [WIDTH-1:0] eng_res;

  assign eng_say__RDY = !eng_busy;
  assign eng_gcd__ENA = eng_busy && (eng_cnt == 0);
  assign eng_gcd_v    = eng_gcd__ENA ? eng_res : '0;

  always @(posedge CLK) begin
    if (!nRST) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
    end else if (eng_say__ENA && eng_say__RDY) begin
      eng_busy <= 1'b1;
      eng_cnt  <= ENG_DELAY;
      eng_res  <= gcd(eng_say_va, eng_say_vb);
    end else if (eng_busy) begin
      if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
      else if (eng_gcd__RDY) eng_busy <= 1'b0;
    end
  end

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] val;
    int               lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic mon_lat_pend = 1'b0;
  int   mon_lat_exp;

  // Monitor: pops on every result transfer; latency is checked the cycle after.
  always @(negedge CLK) begin
    if (mon_lat_pend) begin
      check("last_latency", 64'(last_latency), 64'(mon_lat_exp));
      mon_lat_pend = 1'b0;
    end
    if (nRST && |(ind_gcd__ENA & ind_gcd__RDY)) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'(ind_gcd__ENA), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("ind_gcd__ENA", 64'(ind_gcd__ENA), 64'(1) << mon_e.idx);
        check("ind_gcd_v", 64'(ind_gcd_v), 64'(mon_e.val));
        mon_lat_exp  = mon_e.lat;
        mon_lat_pend = 1'b1;
      end
    end
  end

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_say__ENA[i] = 1'b1;
    req_say_va[i*WIDTH +: WIDTH] = a;
    req_say_vb[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic pulse();
    @(negedge CLK);
    req_say__ENA = '0;
  endtask

  task automatic expect_res(input int i, input logic [WIDTH-1:0] v, input int lat);
    exp_t e;
    e.idx = i;
    e.val = v;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || req_say__RDY != '1 || mon_lat_pend) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) check({name, "_timeout"}, 64'(sb.size()), 64'(0));
  endtask

  task automatic wait_ind(input int i, input string name);
    int n;
    n = 0;
    while (!ind_gcd__ENA[i] && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) check({name, "_timeout"}, 64'(ind_gcd__ENA), 64'(1) << i);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    req_say__ENA = '0;
    req_say_va = '0;
    req_say_vb = '0;
    ind_gcd__RDY = '1;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;

    check("rst_req_rdy", 64'(req_say__RDY), 64'hF);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_eng_ena", 64'(eng_say__ENA), 64'(0));
    check("rst_ind_ena", 64'(ind_gcd__ENA), 64'(0));
    check("rst_latency", 64'(last_latency), 64'(0));

    // Single op
    expect_res(0, 6, ENG_DELAY + 1);
    set_req(0, 12, 18);
    pulse();
    check("single_rdy_loaded", 64'(req_say__RDY[0]), 64'(0));
    check("single_issue_ena", 64'(eng_say__ENA), 64'(1));
    check("single_issue_va", 64'(eng_say_va), 64'(12));
    check("single_issue_vb", 64'(eng_say_vb), 64'(18));
    @(negedge CLK);
    check("single_rdy_after_issue", 64'(req_say__RDY[0]), 64'(1));
    check("single_busy", 64'(busy), 64'(1));
    wait_drain("single");

    // Contention from rr_ptr = 0
    do_reset();
    expect_res(0, 12, ENG_DELAY + 1);
    expect_res(1, 1, ENG_DELAY + 1);
    expect_res(2, 25, ENG_DELAY + 1);
    expect_res(3, 9, ENG_DELAY + 1);
    set_req(0, 48, 36);
    set_req(1, 7, 5);
    set_req(2, 100, 75);
    set_req(3, 0, 9);
    pulse();
    check("contention_first_grant_va", 64'(eng_say_va), 64'(48));
    wait_drain("contention");

    // Rotation: req2 served, then pending {0,3} -> req3 before req0
    expect_res(2, 3, ENG_DELAY + 1);
    expect_res(3, 5, ENG_DELAY + 1);
    expect_res(0, 4, ENG_DELAY + 1);
    set_req(2, 9, 6);
    pulse();
    @(negedge CLK);
    set_req(0, 8, 12);
    set_req(3, 15, 10);
    pulse();
    wait_drain("rotation");

    // Back-pressure on req1 for 5 cycles, req2 waiting behind it
    ind_gcd__RDY[1] = 1'b0;
    expect_res(1, 4, ENG_DELAY + 1 + 5);
    expect_res(2, 9, ENG_DELAY + 1);
    set_req(1, 20, 8);
    pulse();
    set_req(2, 27, 18);
    pulse();
    wait_ind(1, "bp_result");
    for (int s = 0; s < 5; s++) begin
      check("bp_eng_gcd_rdy", 64'(eng_gcd__RDY), 64'(0));
      check("bp_busy", 64'(busy), 64'(1));
      check("bp_no_issue", 64'(eng_say__ENA), 64'(0));
      check("bp_ind_ena", 64'(ind_gcd__ENA), 64'h2);
      @(negedge CLK);
    end
    ind_gcd__RDY[1] = 1'b1;
    wait_drain("backpressure");

    // Pipelined reload of req0
    expect_res(0, 5, ENG_DELAY + 1);
    expect_res(0, 7, ENG_DELAY + 1);
    set_req(0, 35, 10);
    pulse();
    @(negedge CLK);
    check("reload_slot_free", 64'(req_say__RDY[0]), 64'(1));
    set_req(0, 21, 14);
    pulse();
    wait_ind(0, "reload_first");
    @(negedge CLK);
    check("reload_issue_ena", 64'(eng_say__ENA), 64'(1));
    check("reload_issue_va", 64'(eng_say_va), 64'(21));
    check("reload_issue_vb", 64'(eng_say_vb), 64'(14));
    wait_drain("reload");

    // Reset mid-operation with pend = 4'b1010
    set_req(0, 30, 12);
    pulse();
    @(negedge CLK);
    set_req(1, 4, 6);
    set_req(3, 8, 10);
    pulse();
    check("midrst_pend", 64'(req_say__RDY), 64'b0101);
    check("midrst_busy_before", 64'(busy), 64'(1));
    nRST = 1'b0;
    @(negedge CLK);
    check("midrst_req_rdy", 64'(req_say__RDY), 64'hF);
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_eng_ena", 64'(eng_say__ENA), 64'(0));
    check("midrst_ind_ena", 64'(ind_gcd__ENA), 64'(0));
    check("midrst_eng_gcd_rdy", 64'(eng_gcd__RDY), 64'(0));
    check("midrst_latency", 64'(last_latency), 64'(0));
    nRST = 1'b1;
    repeat (6) @(negedge CLK);
    check("post_rst_idle", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
